uart_tx_framer: RTL

Packet framer sitting directly upstream of the UART byte transmitter. Producers push payload bytes into an internal FIFO and then request a frame with a command byte. The block sends SOF, CMD, LEN, payload and an XOR checksum one byte at a time over the transmitter's trmt/tx_data/tx_done handshake. It is the only driver of the transmitter in the stimulator telemetry path.

---
 rtl/uart_tx_framer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: payload FIFO plus a frame sequencer that drives a UART byte
// transmitter with SOF, CMD, LEN, payload bytes and an XOR checksum.
module uart_tx_framer #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] SOF   = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   send,
  input  logic [7:0]             cmd,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  input  logic                   tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CHK,
    S_DONE
  } state_t;

  // Every byte state spends one ISSUE cycle pulsing trmt, then WAITs for tx_done.
  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_t;

  state_t        state_q, state_d;
  phase_t        phase_q, phase_d;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          full_w;
  logic          wr_accept;
  logic          pop;
  logic [7:0]    head;
  logic [7:0]    issue_byte;

  assign full     = full_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  // The ISSUE cycle shows the fresh byte combinationally (including the FIFO
  // head during PAY); afterwards the registered copy holds it until tx_done.
  assign tx_data  = trmt ? issue_byte : tx_data_q;

  // FIFO pointer/count bookkeeping; a write while full is dropped even if a pop
  // frees a slot in the same cycle, because fullness is judged on count_q.
  always_comb begin
    full_w     = (count_q == CW'(DEPTH));
    wr_accept  = wr_en && !full_w;
    overflow_d = wr_en && full_w;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Select the byte that belongs to the current state.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    issue_byte = SOF;
    case (state_q)
      S_CMD:   issue_byte = cmd_q;
      S_LEN:   issue_byte = len_q;
      S_PAY:   issue_byte = head;
      S_CHK:   issue_byte = chk_q;
      default: issue_byte = SOF;
    endcase
  end

  // Frame sequencer: next state, handshake outputs and checksum accumulation.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    chk_d      = chk_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    trmt       = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;

    if (state_q == S_IDLE || state_q == S_DONE) begin
      busy       = 1'b0;
      frame_done = (state_q == S_DONE);
      state_d    = S_IDLE;
      if (send) begin
        // LEN is the count before any same-cycle write lands.
        state_d = S_SOF;
        phase_d = PH_ISSUE;
        cmd_d   = cmd;
        len_d   = 8'(count_q);
        chk_d   = cmd ^ 8'(count_q);
        rem_d   = count_q;
      end
    end else if (phase_q == PH_ISSUE) begin
      // tx_done during ISSUE belongs to nothing of ours and is ignored.
      trmt      = 1'b1;
      tx_data_d = issue_byte;
      phase_d   = PH_WAIT;
      if (state_q == S_PAY) begin
        pop   = 1'b1;
        chk_d = chk_q ^ head;
        rem_d = rem_q - CW'(1);
      end
    end else if (tx_done) begin
      phase_d = PH_ISSUE;
      case (state_q)
        S_SOF:   state_d = S_CMD;
        S_CMD:   state_d = S_LEN;
        S_LEN:   state_d = (len_q != '0) ? S_PAY : S_CHK;
        S_PAY:   state_d = (rem_q != '0) ? S_PAY : S_CHK;
        default: state_d = S_DONE;
      endcase
    end
  end

  // Control state; reset abandons any frame in flight and empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_ISSUE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Frame fields and FIFO storage; always loaded before use, so no reset.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
    len_q <= len_d;
    chk_q <= chk_d;
    rem_q <= rem_d;
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
